// File: rtl/ariane_pkg.sv
// Shared definitions for the perf-counter snapshot path: counter address window,
// snapshot beat layout and the controller state encoding.
package ariane_pkg;

    localparam logic [4:0]  PERF_CNT_FIRST = 5'd3;
    localparam logic [4:0]  PERF_CNT_LAST  = 5'd17;
    localparam int unsigned PERF_SEQ_W     = 16;

    typedef struct packed {
        logic [4:0]            idx;
        logic [63:0]           data;
        logic                  last;
        logic [PERF_SEQ_W-1:0] seq;
    } perf_snap_t;

    typedef enum logic {
        SNAP_IDLE,
        SNAP_SWEEP
    } snap_state_e;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/perf_snapshot_ctrl_timer.sv
// Periodic sweep timer: counts while enabled, raises expire_o for one cycle at
// period_i-1 and restarts. Frozen in debug mode, held at zero when period_i is 0.
module perf_period_timer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        debug_mode_i,
    input  logic [31:0] period_i,
    output logic        expire_o
);

    logic [31:0] timer_q, timer_d;
    logic        enabled;

    always_comb begin
        enabled  = (period_i != 32'd0);
        expire_o = enabled && !debug_mode_i && (timer_q == period_i - 32'd1);
        timer_d  = timer_q;
        if (!enabled) begin
            timer_d = 32'd0;
        end else if (!debug_mode_i) begin
            timer_d = expire_o ? 32'd0 : timer_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= 32'd0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/perf_snapshot_ctrl.sv
// Sweeps NUM_CNT perf counters through the shared counter port and streams each
// value out through a one-entry output register, optionally clearing on read.
module perf_snapshot_ctrl
    import ariane_pkg::*;
#(
    parameter int unsigned NUM_CNT   = 15,
    parameter logic [4:0]  BASE_ADDR = PERF_CNT_FIRST,
    parameter int unsigned SEQ_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             debug_mode_i,
    input  logic             trigger_i,
    input  logic [31:0]      period_i,
    input  logic             clear_on_read_i,
    output logic             perf_req_o,
    input  logic             perf_gnt_i,
    output logic [4:0]       perf_addr_o,
    output logic             perf_we_o,
    output logic [63:0]      perf_data_o,
    input  logic [63:0]      perf_data_i,
    output logic             snap_valid_o,
    input  logic             snap_ready_i,
    output logic [4:0]       snap_idx_o,
    output logic [63:0]      snap_data_o,
    output logic             snap_last_o,
    output logic [SEQ_W-1:0] snap_seq_o,
    output logic             busy_o,
    output logic [15:0]      missed_o
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_CNT - 1);

    // The beat layout is shared with downstream consumers, so the width is fixed there.
    if (SEQ_W != PERF_SEQ_W) begin : g_seq_w_check
        $error("SEQ_W must equal ariane_pkg::PERF_SEQ_W");
    end

    snap_state_e      state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic             pending_q, pending_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [15:0]      missed_q, missed_d;
    perf_snap_t       snap_q, snap_d;
    logic             snap_valid_q, snap_valid_d;

    logic       timer_expire;
    logic       access;
    logic       access_done;
    logic [1:0] req_cnt;
    logic [1:0] leftover;

    perf_period_timer u_timer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .debug_mode_i (debug_mode_i),
        .period_i     (period_i),
        .expire_o     (timer_expire)
    );

    // No prefetch: the port is only touched when the output register can take the result.
    assign access      = (state_q == SNAP_SWEEP) && (!snap_valid_q || snap_ready_i);
    assign access_done = access && perf_gnt_i;
    assign req_cnt     = 2'(trigger_i) + 2'(timer_expire) + 2'(pending_q);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        state_d      = state_q;
        idx_d        = idx_q;
        seq_d        = seq_q;
        missed_d     = missed_q;
        snap_d       = snap_q;
        snap_valid_d = snap_valid_q;
        leftover     = req_cnt;

        if (state_q == SNAP_IDLE) begin
            if (req_cnt != 2'd0) begin
                state_d  = SNAP_SWEEP;
                leftover = req_cnt - 2'd1;
            end
        end else if (access_done) begin
            if (idx_q == LAST_IDX) begin
                idx_d   = 5'd0;
                seq_d   = seq_q + SEQ_W'(1);
                state_d = SNAP_IDLE;
            end else begin
                idx_d = idx_q + 5'd1;
            end
        end

        // Pending absorbs one request; anything beyond that is only counted.
        pending_d = (leftover != 2'd0);
        if (leftover > 2'd1) begin
            missed_d = sat_add16(missed_q, leftover - 2'd1);
        end

        if (access_done) begin
            snap_valid_d = 1'b1;
            snap_d.idx   = idx_q;
            snap_d.data  = perf_data_i;
            snap_d.last  = (idx_q == LAST_IDX);
            snap_d.seq   = seq_q;
        end else if (snap_valid_q && snap_ready_i) begin
            snap_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= SNAP_IDLE;
            idx_q        <= 5'd0;
            pending_q    <= 1'b0;
            seq_q        <= '0;
            missed_q     <= 16'd0;
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q      <= state_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            seq_q        <= seq_d;
            missed_q     <= missed_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign perf_req_o   = access;
    assign perf_we_o    = access && clear_on_read_i;
    assign perf_addr_o  = access ? BASE_ADDR + idx_q : BASE_ADDR;
    assign perf_data_o  = 64'd0;

    assign snap_valid_o = snap_valid_q;
    assign snap_idx_o   = snap_q.idx;
    assign snap_data_o  = snap_q.data;
    assign snap_last_o  = snap_q.last;
    assign snap_seq_o   = snap_q.seq;
    assign busy_o       = (state_q == SNAP_SWEEP) || snap_valid_q;
    assign missed_o     = missed_q;

endmodule

// File: doc/perf_snapshot_ctrl.md
# perf_snapshot_ctrl

Initiator for the performance-counter SRAM-like port: sweeps a contiguous window of counter addresses, returning each value on a valid/ready stream, with optional read-and-clear. It sits between the core's trace/debug egress and the perf counter block. A sweep starts on a software trigger or on a programmable periodic timer. External logic muxes this block onto the counter port; the CSR file has priority through a grant input.

## Interface
Parameters:
- NUM_CNT, 15: number of counters per sweep.
- BASE_ADDR, 5'd3: counter address of the first counter.
- SEQ_W, 16: sweep sequence-number width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- debug_mode_i  in  1  freezes the period timer
- trigger_i  in  1  single-cycle sweep request
- period_i  in  32  auto-sweep period in cycles; 0 disables the timer
- clear_on_read_i  in  1  zero each counter as it is read
- perf_req_o  out  1  port access request
- perf_gnt_i  in  1  access performed this cycle
- perf_addr_o  out  5  counter address
- perf_we_o  out  1  write enable; only asserted together with perf_req_o
- perf_data_o  out  64  write data; always 0
- perf_data_i  in  64  read data, combinational from the counter block
- snap_valid_o  out  1  stream valid
- snap_ready_i  in  1  stream ready
- snap_idx_o  out  5  counter index, 0..NUM_CNT-1
- snap_data_o  out  64  counter value
- snap_last_o  out  1  last beat of the sweep
- snap_seq_o  out  SEQ_W  sweep number
- busy_o  out  1  sweep in progress
- missed_o  out  16  saturating count of coalesced requests

## Operation
- FSM has two states: IDLE and SWEEP. Registers:
  - idx
  - timer (32 b)
  - pending bit
  - one-entry output register (valid, idx, data, last, seq)
  - seq
  - missed
- **Request sources:**
  - trigger_i.
  - Timer expiry. When period_i≠0 and debug_mode_i=0, timer increments every cycle. At timer==period_i-1 it resets to 0 and raises a request. A change of period_i takes effect on the next compare. period_i=0 holds timer at 0.
- **Request handling:**
  - A request raised in IDLE enters SWEEP on the next edge.
  - A request raised in SWEEP sets pending.
  - A request raised while pending is already set, or two requests in the same cycle beyond what pending can absorb, increments missed (saturates at 0xFFFF).
  - Pending is consumed when SWEEP returns to IDLE, so the next sweep starts with one IDLE cycle in between.
- **SWEEP access:**
  - perf_req_o=1 and perf_addr_o=BASE_ADDR+idx exactly when the output register is free (snap_valid_o=0, or snap_ready_i=1).
  - perf_we_o=clear_on_read_i.
- **Access completion (perf_req_o & perf_gnt_i):**
  - Output register loads {idx, perf_data_i, idx==NUM_CNT-1, seq}. Loaded data is the pre-write value.
  - idx increments.
  - On the last index, idx returns to 0, seq increments (wraps), and the FSM goes to IDLE.
- A counter increment coinciding with its clear is lost. This is accepted behaviour.
- A deasserted grant stalls the access; address and we are held.
- The output register clears valid on snap_valid_o & snap_ready_i unless it reloads in the same cycle.
- **Idle port state:** perf_req_o=0, perf_we_o=0, perf_addr_o=BASE_ADDR, perf_data_o=0.
- busy_o = (state==SWEEP) | snap_valid_o.
- **Reset values:** all outputs 0 except perf_addr_o=BASE_ADDR; state IDLE; timer, idx, seq, missed, pending all 0. Reset mid-sweep abandons the sweep and drops the stream beat; no partial completion.

## Timing
- trigger_i in cycle t → first access at t+1. snap_valid_o for idx 0 from t+2, carrying the value read at t+1.
- With grant and ready held high: one beat per cycle; snap_last_o at t+NUM_CNT+1; state back to IDLE at t+NUM_CNT+1.
- A pending request starts its sweep at t+NUM_CNT+2.
- Backpressure: when snap_ready_i=0 with the output register full, no port access occurs; the counters are read later (no prefetch).
- Stream rule: once snap_valid_o is asserted, snap_idx_o, snap_data_o, snap_last_o and snap_seq_o are stable until the handshake completes.

## Structure
- The shared package (ariane_pkg) holds:
  - the perf counter address window constants (first/last counter CSR low bits)
  - a perf_snap_t struct {idx, data, last, seq}
- One natural sub-module: perf_period_timer, containing the timer, the compare and the debug freeze.
- The FSM and the output register stay in the top module.

## Test plan
- **Basic sweep:** preload counters 3..17 with 100+i; trigger, ready=1, gnt=1 → 15 beats, idx 0..14, data 100..114, last on idx 14, seq 0.
- **Read-and-clear:** clear_on_read_i=1; trigger → beats carry the old values; a second sweep returns 0 for counters that did not increment in between.
- **Backpressure and grant:** ready toggles 1-0-0-1, gnt low for 3 cycles at idx 5 → no duplicated or skipped idx; address held during the stall; no access while the output register is full.
- **Periodic mode:** period_i=40, ready=1 → sweeps start every 40 cycles; debug_mode_i=1 for 10 cycles delays the next start by 10.
- **Coalescing:** three triggers during one sweep → exactly one extra sweep (seq 1), missed_o=2.
- **Reset mid-sweep:** assert rst_ni low at idx 7 → all outputs at their reset values; a trigger after reset restarts at idx 0 with seq 0.
